// File: rtl/full_subtractor_if.sv
// full_subtractor_if
//   Groups the operand, fault-injection, self-test control and result
//   signals of the full_subtractor cell into one bundle.
//   master : drives A/B/Bin, sa0_mask and bist_start; observes all results.
//   slave  : the subtractor cell itself.
//   Signals:
//     A, B, Bin   operand bits (minuend, subtrahend, borrow in)
//     sa0_mask    stuck-at-0 injection {A,B,Bin}
//     bist_start  one-cycle self-test start pulse
//     D, Bout     combinational difference / borrow out
//     D_r, Bout_r registered copies (one cycle latency)
//     bist_busy, bist_done, fault_flag, fault_code, mismatch  self-test status
interface full_subtractor_if;
   logic       A;
   logic       B;
   logic       Bin;
   logic [2:0] sa0_mask;
   logic       bist_start;
   logic       D;
   logic       Bout;
   logic       D_r;
   logic       Bout_r;
   logic       bist_busy;
   logic       bist_done;
   logic       fault_flag;
   logic [2:0] fault_code;
   logic       mismatch;

   modport master (
      output A, B, Bin, sa0_mask, bist_start,
      input  D, Bout, D_r, Bout_r, bist_busy, bist_done,
             fault_flag, fault_code, mismatch
   );

   modport slave (
      input  A, B, Bin, sa0_mask, bist_start,
      output D, Bout, D_r, Bout_r, bist_busy, bist_done,
             fault_flag, fault_code, mismatch
   );
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor
//   1-bit full subtractor (D = A-B-Bin difference, Bout = borrow out) with a
//   registered output copy, stuck-at-0 fault injection on the three inputs and
//   a built-in self-test that walks all 8 input vectors, flags any disagreement
//   with a fault-free golden model and classifies which inputs are stuck at 0.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  full_subtractor_if.slave (operands, mask, BIST control and status)
module full_subtractor (
   input  logic              clk,
   input  logic              rst,
   full_subtractor_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state_reg, state_next;
   logic [2:0] index_reg;
   logic       fault_flag_reg;
   logic [2:0] fault_code_reg;
   logic       mismatch_reg;
   logic       d_r_reg, bout_r_reg;

   logic       busy, done;
   logic       start_accept;
   logic [2:0] bist_vec;
   logic [2:0] src_vec;
   logic [2:0] int_vec;
   logic       d_int, bout_int;
   logic       d_gold, bout_gold;
   logic       cls_hit;
   logic [2:0] cls_code;

   // Vector order: count 000..011, then walk down from 111 so that the last
   // four vectors all have A=1 and expose the stuck-input signatures.
   always_comb begin
      bist_vec = 3'b000;
      case (index_reg)
         3'd0: bist_vec = 3'b000;
         3'd1: bist_vec = 3'b001;
         3'd2: bist_vec = 3'b010;
         3'd3: bist_vec = 3'b011;
         3'd4: bist_vec = 3'b111;
         3'd5: bist_vec = 3'b110;
         3'd6: bist_vec = 3'b101;
         3'd7: bist_vec = 3'b100;
         default: bist_vec = 3'b000;
      endcase
   end

   assign src_vec = busy ? bist_vec : {bus.A, bus.B, bus.Bin};

   // Stuck-at-0 injection, bit by bit.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_mask
         assign int_vec[gi] = src_vec[gi] & ~bus.sa0_mask[gi];
      end
   endgenerate

   assign d_int     = ^int_vec;
   assign bout_int  = (~int_vec[2] & int_vec[1]) | (~int_vec[2] & int_vec[0])
                    | (int_vec[1] & int_vec[0]);
   assign d_gold    = ^src_vec;
   assign bout_gold = (~src_vec[2] & src_vec[1]) | (~src_vec[2] & src_vec[0])
                    | (src_vec[1] & src_vec[0]);

   // Signature table: only meaningful on the A=1 half of the sweep.
   always_comb begin
      cls_hit  = 1'b0;
      cls_code = 3'b000;
      if (index_reg[2]) begin
         case ({bist_vec, d_int, bout_int})
            5'b111_01: begin cls_hit = 1'b1; cls_code = 3'b100; end
            5'b111_10: begin cls_hit = 1'b1; cls_code = 3'b011; end
            5'b110_10: begin cls_hit = 1'b1; cls_code = 3'b010; end
            5'b110_11: begin cls_hit = 1'b1; cls_code = 3'b101; end
            5'b101_10: begin cls_hit = 1'b1; cls_code = 3'b001; end
            5'b101_11: begin cls_hit = 1'b1; cls_code = 3'b110; end
            5'b100_00: begin cls_hit = 1'b1; cls_code = 3'b111; end
            default:   begin cls_hit = 1'b0; cls_code = 3'b000; end
         endcase
      end
   end

   assign start_accept = (state_reg != RUN) && bus.bist_start;

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.bist_start) state_next = RUN;
         RUN:     if (index_reg == 3'd7) state_next = DONE;
         DONE:    if (bus.bist_start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_reg == RUN);
      done = (state_reg == DONE);
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_r_reg        <= 1'b0;
         bout_r_reg     <= 1'b0;
         index_reg      <= 3'd0;
         fault_flag_reg <= 1'b0;
         fault_code_reg <= 3'b000;
         mismatch_reg   <= 1'b0;
      end else begin
         d_r_reg    <= d_int;
         bout_r_reg <= bout_int;
         if (start_accept) begin
            index_reg      <= 3'd0;
            fault_flag_reg <= 1'b0;
            fault_code_reg <= 3'b000;
            mismatch_reg   <= 1'b0;
         end else if (busy) begin
            index_reg <= index_reg + 3'd1;
            if ((d_int != d_gold) || (bout_int != bout_gold))
               mismatch_reg <= 1'b1;
            // First signature wins; later ones are ignored.
            if (cls_hit && !fault_flag_reg) begin
               fault_flag_reg <= 1'b1;
               fault_code_reg <= cls_code;
            end
         end
      end
   end

   assign bus.D          = d_int;
   assign bus.Bout       = bout_int;
   assign bus.D_r        = d_r_reg;
   assign bus.Bout_r     = bout_r_reg;
   assign bus.bist_busy  = busy;
   assign bus.bist_done  = done;
   assign bus.fault_flag = fault_flag_reg;
   assign bus.fault_code = fault_code_reg;
   assign bus.mismatch   = mismatch_reg;

endmodule

// File: tb/tb_full_subtractor.sv
// tb_full_subtractor
//   Randomized self-checking bench for full_subtractor. The reference model
//   computes A-B-Bin with integer arithmetic and replays the self-test sweep
//   from the vector list and the signature table.
module tb_full_subtractor;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   full_subtractor_if bus();

   full_subtractor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int vec_order[8] = '{0, 1, 2, 3, 7, 6, 5, 4};

   task automatic check_value(input string tag, input logic [7:0] got,
                              input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {D, Bout} from plain subtraction of three bits.
   function automatic logic [1:0] sub_model(input logic [2:0] v);
      int diff;
      logic d, bo;
      diff = int'(v[2]) - int'(v[1]) - int'(v[0]);
      d  = ((diff % 2) != 0);
      bo = (diff < 0);
      return {d, bo};
   endfunction

   // Signature table; returns -1 when the observation is not a signature.
   function automatic int classify(input logic [2:0] v, input logic [1:0] db);
      case ({v, db})
         5'b111_01: return 4;
         5'b111_10: return 3;
         5'b110_10: return 2;
         5'b110_11: return 5;
         5'b101_10: return 1;
         5'b101_11: return 6;
         5'b100_00: return 7;
         default:   return -1;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_bist(input logic [2:0] mask, input bit extra_start);
      logic       exp_mm, exp_flag;
      logic [2:0] exp_code, v;
      logic [1:0] got_db, gold_db;
      int         cycles, c;

      // Expected results from the sweep.
      exp_mm = 0; exp_flag = 0; exp_code = 0;
      for (int i = 0; i < 8; i++) begin
         v       = 3'(vec_order[i]);
         got_db  = sub_model(v & ~mask);
         gold_db = sub_model(v);
         if (got_db != gold_db) exp_mm = 1;
         if (i >= 4 && !exp_flag) begin
            c = classify(v, got_db);
            if (c >= 0) begin
               exp_flag = 1;
               exp_code = 3'(c);
            end
         end
      end

      bus.sa0_mask   = mask;
      bus.bist_start = 1'b1;
      step();
      bus.bist_start = 1'b0;
      check_value("start_busy", 8'(bus.bist_busy), 8'd1);
      check_value("start_done_clr", 8'(bus.bist_done), 8'd0);
      check_value("start_res_clr",
                  8'({bus.fault_flag, bus.fault_code, bus.mismatch}), 8'd0);

      cycles = 0;
      while (bus.bist_busy === 1'b1 && cycles < 20) begin
         if (cycles < 8) begin
            v = 3'(vec_order[cycles]);
            check_value("bist_out", 8'({bus.D, bus.Bout}), 8'(sub_model(v & ~mask)));
         end
         bus.A   = 1'($urandom);
         bus.B   = 1'($urandom);
         bus.Bin = 1'($urandom);
         bus.bist_start = (extra_start && cycles == 3);
         cycles++;
         step();
      end
      bus.bist_start = 1'b0;

      check_value("run_len", 8'(cycles), 8'd8);
      check_value("done", 8'({bus.bist_done, bus.bist_busy}), 8'b10);
      check_value("fault_flag", 8'(bus.fault_flag), 8'(exp_flag));
      check_value("fault_code", 8'(bus.fault_code), 8'(exp_code));
      check_value("mismatch", 8'(bus.mismatch), 8'(exp_mm));
      $display("bist mask=%b extra_start=%0d cycles=%0d flag=%b code=%b mismatch=%b",
               mask, extra_start, cycles, bus.fault_flag, bus.fault_code, bus.mismatch);
   endtask

   initial begin
      logic [2:0] v, m;
      logic [1:0] exp_db, prev_db;

      rst = 1'b1;
      bus.A = 0; bus.B = 0; bus.Bin = 0;
      bus.sa0_mask = 3'b000;
      bus.bist_start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_value("reset_state",
                  8'({bus.D_r, bus.Bout_r, bus.bist_busy, bus.bist_done,
                      bus.fault_flag, bus.mismatch}), 8'd0);
      check_value("reset_code", 8'(bus.fault_code), 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Exhaustive then random combinational operation.
      prev_db = 2'b00;
      for (int n = 0; n < 48; n++) begin
         if (n < 8) begin
            v = 3'(n);
            m = 3'b000;
         end else begin
            v = 3'($urandom_range(0, 7));
            m = 3'($urandom_range(0, 7));
         end
         {bus.A, bus.B, bus.Bin} = v;
         bus.sa0_mask = m;
         @(negedge clk);
         exp_db = sub_model(v & ~m);
         check_value("comb", 8'({bus.D, bus.Bout}), 8'(exp_db));
         if (n > 0)
            check_value("registered", 8'({bus.D_r, bus.Bout_r}), 8'(prev_db));
         $display("comb v=%b mask=%b D=%b Bout=%b D_r=%b Bout_r=%b",
                  v, m, bus.D, bus.Bout, bus.D_r, bus.Bout_r);
         prev_db = exp_db;
         step();
      end

      // Every mask, including fault-free and all-stuck.
      run_bist(3'b000, 0);
      run_bist(3'b100, 0);
      run_bist(3'b010, 0);
      run_bist(3'b001, 0);
      run_bist(3'b011, 0);
      run_bist(3'b101, 0);
      run_bist(3'b110, 0);
      run_bist(3'b111, 0);

      // Start pulse in the middle of a run is ignored.
      run_bist(3'b010, 1);

      // Reset in the middle of a run at index 3.
      bus.sa0_mask   = 3'b000;
      bus.bist_start = 1'b1;
      step();
      bus.bist_start = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      check_value("midrun_reset",
                  8'({bus.D_r, bus.Bout_r, bus.bist_busy, bus.bist_done,
                      bus.fault_flag, bus.mismatch}), 8'd0);
      check_value("midrun_code", 8'(bus.fault_code), 8'd0);
      $display("reset during run: busy=%b done=%b", bus.bist_busy, bus.bist_done);
      step();
      rst = 1'b0;
      step();
      check_value("after_reset_idle", 8'({bus.bist_busy, bus.bist_done}), 8'd0);

      // Random masks, then a restart after DONE clearing a faulty result.
      for (int k = 0; k < 4; k++)
         run_bist(3'($urandom_range(0, 7)), 1'($urandom));
      run_bist(3'b111, 0);
      run_bist(3'b000, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- 1-bit full subtractor computing difference and borrow-out from minuend A, subtrahend B and borrow-in Bin; D and Bout are purely combinational.
- Adds a registered output copy, a stuck-at-0 fault-injection mask on the three inputs, and a built-in self-test (BIST) engine that exercises all 8 input vectors and classifies input stuck-at-0 faults.
- Used as a leaf arithmetic cell and as a DFT demonstrator.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- A  input  1  minuend
- B  input  1  subtrahend
- Bin  input  1  borrow in
- sa0_mask  input  3  fault injection; bit2 forces internal A=0, bit1 forces internal B=0, bit0 forces internal Bin=0
- bist_start  input  1  single-cycle pulse; starts self-test (ignored while bist_busy=1)
- D  output  1  difference, combinational
- Bout  output  1  borrow out, combinational
- D_r  output  1  D registered, 1-cycle latency
- Bout_r  output  1  Bout registered, 1-cycle latency
- bist_busy  output  1  self-test running
- bist_done  output  1  self-test complete; held until next start or reset
- fault_flag  output  1  a stuck-at-0 signature was classified
- fault_code  output  3  stuck inputs as a bitmask {A,B,Bin}; 000 = none
- mismatch  output  1  any of the 8 vectors disagreed with the golden model

Behaviour:
- Source vector {a,b,c}:
  - {A,B,Bin} when bist_busy=0.
  - BIST vector otherwise.
- Internal vector = source vector AND NOT sa0_mask, bitwise.
- Output equations on the internal vector: D = a^b^c; Bout = (~a&b) | (~a&c) | (b&c).
- Golden model: same equations on the unmasked source vector.
- Reset state:
  - D_r, Bout_r, bist_busy, bist_done, fault_flag, mismatch = 0.
  - fault_code = 000; vector index = 0; FSM = IDLE.
- D_r/Bout_r capture D/Bout every clock, including during BIST.
- FSM states IDLE, RUN, DONE.
  - IDLE or DONE with bist_start=1: go to RUN at the next edge.
    - index=0, bist_busy=1, bist_done=0.
    - fault_flag, fault_code, mismatch cleared.
  - RUN: one vector per cycle, in this order: 000, 001, 010, 011, 111, 110, 101, 100.
  - Each RUN cycle: compare D/Bout with the golden model; any difference sets mismatch (sticky).
  - After index 7 is evaluated: go to DONE, bist_busy=0, bist_done=1.
- Classification: evaluated at indices 4-7. The first match wins; once fault_flag=1, later matches are ignored.
  - Vector 111:
    - D=0, Bout=1 -> code 100.
    - D=1, Bout=0 -> code 011.
  - Vector 110:
    - D=1, Bout=0 -> code 010.
    - D=1, Bout=1 -> code 101.
  - Vector 101:
    - D=1, Bout=0 -> code 001.
    - D=1, Bout=1 -> code 110.
  - Vector 100:
    - D=0, Bout=0 -> code 111.
  - On a match: fault_flag=1, fault_code=code.
- No match in a fault-free run: fault_flag=0, fault_code=000, mismatch=0.
- bist_start while in RUN is ignored.
- rst asserted mid-run immediately returns the block to reset state.
- sa0_mask changes take effect combinationally, including mid-BIST.

Test Plan:
- Exhaustive functional check, sa0_mask=000, bist idle, all 8 {A,B,Bin}:
  - D = parity.
  - Bout = 1 for 001, 010, 011, 111; 0 otherwise.
  - D_r/Bout_r equal the previous cycle's values.
- BIST with sa0_mask=000 -> bist_done=1 after 8 RUN cycles; fault_flag=0, fault_code=000, mismatch=0.
- BIST, one input stuck:
  - sa0_mask=100 -> fault_code=100.
  - sa0_mask=010 -> fault_code=010.
  - sa0_mask=001 -> fault_code=001.
  - mismatch=1 and fault_flag=1 in each case.
- BIST, two inputs stuck -> fault_code equals the mask:
  - sa0_mask=011 -> 011.
  - sa0_mask=101 -> 101.
  - sa0_mask=110 -> 110.
- BIST with sa0_mask=111 -> fault_code=111, classified at vector 100.
- Control corner cases:
  - Assert rst during RUN at index 3 -> all outputs return to reset values on the next sample.
  - A bist_start pulse during RUN has no effect; a new start after DONE clears the previous results.
